stage_mem: RTL and testbench
============================

Name: stage_mem

Overview:
- Memory-access pipeline stage, directly downstream of the execute stage.
- Consumes the ALU result (effective address or pass-through value) and the forwarded store data, and drives a single-outstanding request/ack data bus.
- Stalls the upstream pipeline for the duration of each load or store.
- Produces the write-back value plus load/store misaligned and access-fault exception reports.

Parameters:
TIMEOUT, 16, max cycles in BUSY waiting for dbus_ack before declaring an access fault (must be >= 2)

Ports:
clk  in  1  clock
rstn  in  1  reset; synchronous, active-low
me_valid  in  1  valid instruction present in MEM
me_mem_read  in  1  instruction is a load
me_mem_write  in  1  instruction is a store
me_func3_code  in  3  load: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; store: 0 SB, 1 SH, 2 SW
me_alu_o  in  32  effective address, or result for non-memory instructions
me_regs_data2  in  32  store data, already forwarded
me_stall  out  1  hold EX/MEM and all upstream registers
me_wb_data  out  32  value forwarded to write-back
me_done  out  1  one-cycle pulse: memory access finished (with or without fault)
me_exc  out  1  fault qualifier, valid with me_done
me_exc_cause  out  4  4 load misaligned, 5 load access fault, 6 store misaligned, 7 store access fault
me_exc_tval  out  32  faulting address
dbus_req  out  1  bus request
dbus_we  out  1  write enable
dbus_addr  out  32  word address, bits [1:0] always 0
dbus_wdata  out  32  lane-replicated store data
dbus_be  out  4  byte enables
dbus_ack  in  1  transfer complete; dbus_rdata valid in the same cycle
dbus_rdata  in  32  read data
dbus_err  in  1  bus error; ends the transfer even without ack

Behaviour:
- FSM states: IDLE, BUSY, DONE. Reset (rstn=0 at posedge) enters IDLE.
- Reset values: all registered outputs 0 (dbus_*, me_done, me_exc, me_exc_cause, me_exc_tval, load data register); timeout counter 0.
- Access request: acc = me_valid & (me_mem_read | me_mem_write). If both read and write are set, the access is a store.
- me_stall = (IDLE & acc) | BUSY. It is combinational and 0 in DONE.
- DONE is the cycle in which the instruction leaves MEM.
- Alignment faults: LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]≠0, are misaligned.
- Illegal func3 is an access fault: load func3 ∈ {3,6,7}; store func3 ≥ 3.
- IDLE & acc & fault: go to DONE next cycle; no bus activity. At DONE: me_done=1, me_exc=1, cause set, tval = me_alu_o.
- IDLE & acc & legal access: at the next posedge, register dbus_req=1, dbus_we, dbus_addr = {addr[31:2],2'b0}, dbus_wdata, dbus_be; enter BUSY; counter=0.
- BUSY holds all dbus_* outputs stable until the transfer ends.
  - dbus_err=1 (priority over ack): enter DONE with access fault (cause 5 or 7).
  - dbus_ack=1: enter DONE; for a load, register the extracted value.
  - Otherwise counter++. If counter == TIMEOUT-1 with no ack, enter DONE with access fault.
  - Every exit from BUSY clears dbus_req on the same edge.
- Store lanes:
  - SB: wdata = {4{d[7:0]}}, be = 4'b0001 << addr[1:0].
  - SH: wdata = {2{d[15:0]}}, be = 4'b0011 << addr[1:0].
  - SW: wdata = d, be = 4'b1111.
- Load extract: v = dbus_rdata >> (8*addr[1:0]).
  - LB / LH sign-extend v[7:0] / v[15:0].
  - LBU / LHU zero-extend.
  - LW uses v unchanged.
- DONE: me_done=1 for exactly one cycle, then unconditional return to IDLE. Bus inputs and me_* inputs are ignored in DONE.
- me_wb_data:
  - In DONE for a load without fault: the registered load value.
  - Otherwise: me_alu_o combinationally. Non-memory instructions pass through with zero latency, no stall and no me_done.
- dbus_ack or dbus_err while in IDLE or DONE is ignored.
- Reset mid-transaction: state returns to IDLE and dbus_req drops on that edge. The transfer is abandoned; a late ack is ignored.
- me_valid dropping while BUSY is ignored; the started transfer completes.

Test Plan:
- LB at 0x1003, ack after 2 cycles with rdata 0x80AABBCC → stall 3 cycles (IDLE + 2 BUSY); dbus_addr 0x1000; DONE with me_wb_data 0xFFFFFF80, me_done pulse 1 cycle.
- SH at 0x2002, data 0x1234ABCD, ack in 1st BUSY cycle → dbus_we=1, be=4'b1100, wdata 0xABCDABCD; no exception.
- LW at 0x3001 → no dbus_req ever; DONE next cycle with me_exc=1, cause 4, tval 0x3001.
- SW at 0x4000, never ack, TIMEOUT=16 → dbus_req held 16 cycles, then DONE with cause 7, tval 0x4000; dbus_req=0 in DONE.
- LHU at 0x5002 with dbus_err=1 and ack=1 in the same cycle → cause 5, no load data; me_wb_data = me_alu_o.
- rstn=0 during BUSY → next cycle dbus_req=0, me_stall reflects IDLE. An ack one cycle later produces no me_done; an ADD with me_alu_o 0x77 passes through with stall 0.

Source files
------------

// File: rtl/stage_mem_if.sv
// Data-bus interface between the memory-access stage and the memory system.
// Single outstanding request; the master holds every request field stable
// until dbus_ack or dbus_err ends the transfer.
//   dbus_req   master->slave  request valid
//   dbus_we    master->slave  write enable
//   dbus_addr  master->slave  word address (bits [1:0] are 0)
//   dbus_wdata master->slave  lane-replicated store data
//   dbus_be    master->slave  byte enables
//   dbus_ack   slave->master  transfer complete, dbus_rdata valid this cycle
//   dbus_rdata slave->master  read data
//   dbus_err   slave->master  bus error, ends the transfer
interface stage_mem_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_be;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
    logic        dbus_err;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
        input  dbus_ack, dbus_rdata, dbus_err
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
        output dbus_ack, dbus_rdata, dbus_err
    );
endinterface

// File: rtl/stage_mem.sv
// Memory-access pipeline stage. Turns an execute-stage load/store into one
// data-bus transfer, stalls upstream while it is in flight, and reports the
// write-back value plus misaligned / access-fault exceptions.
// Ports:
//   clk, rstn           clock, synchronous active-low reset
//   me_valid            instruction present in MEM
//   me_mem_read/_write  load / store (both set: store)
//   me_func3_code       access width and signedness
//   me_alu_o            effective address or non-memory result
//   me_regs_data2       forwarded store data
//   me_stall            combinational hold for EX/MEM and upstream
//   me_wb_data          combinational write-back value
//   me_done             one-cycle pulse when the access finishes
//   me_exc, me_exc_cause, me_exc_tval   exception report, valid with me_done
//   bus                 data-bus master port
module stage_mem #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        me_valid,
    input  logic        me_mem_read,
    input  logic        me_mem_write,
    input  logic [2:0]  me_func3_code,
    input  logic [31:0] me_alu_o,
    input  logic [31:0] me_regs_data2,
    output logic        me_stall,
    output logic [31:0] me_wb_data,
    output logic        me_done,
    output logic        me_exc,
    output logic [3:0]  me_exc_cause,
    output logic [31:0] me_exc_tval,
    stage_mem_if.master bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state_q, state_d;

    logic             req_q, req_d, we_q, we_d;
    logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic             done_d, exc_d;
    logic [3:0]       cause_d;
    logic [31:0]      tval_d;
    logic [31:0]      load_q, load_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      ea_q, ea_d;
    logic             st_q, st_d;
    logic [2:0]       f3_q, f3_d;

    logic        acc, is_store, illegal, misaligned, fault, timeout;
    logic [3:0]  fault_cause;
    logic [31:0] st_wdata, rd_shift, load_ext;
    logic [3:0]  st_be;

    // Request decode and exception classification for the incoming instruction
    always_comb begin
        acc      = me_valid & (me_mem_read | me_mem_write);
        is_store = me_mem_write;
        if (is_store) illegal = (me_func3_code >= 3'd3);
        else          illegal = (me_func3_code == 3'd3) || (me_func3_code[2:1] == 2'b11);
        case (me_func3_code[1:0])
            2'd1:    misaligned = me_alu_o[0];
            2'd2:    misaligned = |me_alu_o[1:0];
            default: misaligned = 1'b0;
        endcase
        fault = illegal | misaligned;
        // Illegal width takes precedence and is reported as an access fault
        if (illegal) fault_cause = is_store ? 4'd7 : 4'd5;
        else         fault_cause = is_store ? 4'd6 : 4'd4;
    end

    // Store lane replication and byte enables
    always_comb begin
        case (me_func3_code[1:0])
            2'd0: begin
                st_wdata = {4{me_regs_data2[7:0]}};
                st_be    = 4'(4'b0001 << me_alu_o[1:0]);
            end
            2'd1: begin
                st_wdata = {2{me_regs_data2[15:0]}};
                st_be    = 4'(4'b0011 << me_alu_o[1:0]);
            end
            default: begin
                st_wdata = me_regs_data2;
                st_be    = 4'b1111;
            end
        endcase
    end

    // Load alignment and sign/zero extension from the captured address/width
    always_comb begin
        rd_shift = bus.dbus_rdata >> {ea_q[1:0], 3'b000};
        case (f3_q)
            3'd0:    load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'd1:    load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'd4:    load_ext = {24'd0, rd_shift[7:0]};
            3'd5:    load_ext = {16'd0, rd_shift[15:0]};
            default: load_ext = rd_shift;
        endcase
    end

    assign timeout = (cnt_q == CNT_LAST);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (acc) state_d = fault ? DONE : BUSY;
            BUSY:    if (bus.dbus_err || bus.dbus_ack || timeout) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM output logic: next values of all registered outputs and context
    always_comb begin
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        done_d  = 1'b0;
        exc_d   = 1'b0;
        cause_d = me_exc_cause;
        tval_d  = me_exc_tval;
        load_d  = load_q;
        cnt_d   = cnt_q;
        ea_d    = ea_q;
        st_d    = st_q;
        f3_d    = f3_q;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    ea_d = me_alu_o;
                    st_d = is_store;
                    f3_d = me_func3_code;
                    if (fault) begin
                        done_d  = 1'b1;
                        exc_d   = 1'b1;
                        cause_d = fault_cause;
                        tval_d  = me_alu_o;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = is_store;
                        addr_d  = {me_alu_o[31:2], 2'b00};
                        wdata_d = st_wdata;
                        be_d    = st_be;
                        cnt_d   = '0;
                    end
                end
            end
            BUSY: begin
                // Error outranks ack; timeout only when neither arrived
                if (bus.dbus_err || (!bus.dbus_ack && timeout)) begin
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    exc_d   = 1'b1;
                    cause_d = st_q ? 4'd7 : 4'd5;
                    tval_d  = ea_q;
                end else if (bus.dbus_ack) begin
                    req_d  = 1'b0;
                    done_d = 1'b1;
                    if (!st_q) load_d = load_ext;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and access context
    always_ff @(posedge clk) begin
        if (!rstn) begin
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            me_done      <= 1'b0;
            me_exc       <= 1'b0;
            me_exc_cause <= '0;
            me_exc_tval  <= '0;
            load_q       <= '0;
            cnt_q        <= '0;
            ea_q         <= '0;
            st_q         <= 1'b0;
            f3_q         <= '0;
        end else begin
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            me_done      <= done_d;
            me_exc       <= exc_d;
            me_exc_cause <= cause_d;
            me_exc_tval  <= tval_d;
            load_q       <= load_d;
            cnt_q        <= cnt_d;
            ea_q         <= ea_d;
            st_q         <= st_d;
            f3_q         <= f3_d;
        end
    end

    assign bus.dbus_req   = req_q;
    assign bus.dbus_we    = we_q;
    assign bus.dbus_addr  = addr_q;
    assign bus.dbus_wdata = wdata_q;
    assign bus.dbus_be    = be_q;

    // Stall while a request is pending in IDLE or a transfer is in flight
    assign me_stall   = ((state_q == IDLE) && acc) || (state_q == BUSY);
    // Only a completed, fault-free load replaces the pass-through value
    assign me_wb_data = ((state_q == DONE) && !st_q && !me_exc) ? load_q : me_alu_o;

endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem: each access pushes its expected completion
// into a scoreboard queue, which is popped and compared when me_done fires.
module tb_stage_mem;
    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic        me_valid, me_mem_read, me_mem_write;
    logic [2:0]  me_func3_code;
    logic [31:0] me_alu_o, me_regs_data2;
    logic        me_stall, me_done, me_exc;
    logic [31:0] me_wb_data, me_exc_tval;
    logic [3:0]  me_exc_cause;

    stage_mem_if bus();

    stage_mem #(.TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .me_valid      (me_valid),
        .me_mem_read   (me_mem_read),
        .me_mem_write  (me_mem_write),
        .me_func3_code (me_func3_code),
        .me_alu_o      (me_alu_o),
        .me_regs_data2 (me_regs_data2),
        .me_stall      (me_stall),
        .me_wb_data    (me_wb_data),
        .me_done       (me_done),
        .me_exc        (me_exc),
        .me_exc_cause  (me_exc_cause),
        .me_exc_tval   (me_exc_tval),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        exc;
        logic [3:0]  cause;
        logic [31:0] tval;
        logic [31:0] wb;
    } exp_t;

    exp_t sbq[$];
    int checks   = 0;
    int failures = 0;

    function automatic exp_t mk(input logic exc, input logic [3:0] cause,
                                input logic [31:0] tval, input logic [31:0] wb);
        exp_t e;
        e.exc = exc; e.cause = cause; e.tval = tval; e.wb = wb;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one access, respond on the bus at BUSY cycle ack_at (0 = never),
    // then check the completion against the scoreboard head.
    task automatic access(input string name, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] d2,
                          input int ack_at, input logic use_err, input logic [31:0] rdata,
                          input exp_t e, input int exp_stall, input int exp_req,
                          output logic [31:0] o_addr, output logic [31:0] o_wdata,
                          output logic [3:0] o_be, output logic o_we);
        int   stall_cnt = 0;
        int   busy = 0;
        logic seen = 1'b0;
        exp_t ev;
        o_addr = '0; o_wdata = '0; o_be = '0; o_we = 1'b0;
        sbq.push_back(e);
        me_valid = 1'b1; me_mem_read = rd; me_mem_write = wr;
        me_func3_code = f3; me_alu_o = alu; me_regs_data2 = d2;
        bus.dbus_rdata = rdata;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (me_done) begin
                seen = 1'b1;
                break;
            end
            if (me_stall) stall_cnt++;
            if (bus.dbus_req) begin
                busy++;
                if (busy == 1) begin
                    o_addr = bus.dbus_addr; o_wdata = bus.dbus_wdata;
                    o_be = bus.dbus_be; o_we = bus.dbus_we;
                end
            end
            bus.dbus_ack = (busy != 0) && (busy == ack_at);
            bus.dbus_err = use_err && (busy != 0) && (busy == ack_at);
            @(posedge clk);
            #1;
        end
        bus.dbus_ack = 1'b0;
        bus.dbus_err = 1'b0;
        chk($sformatf("%s_done_seen", name), 32'(seen), 32'd1);
        ev = (sbq.size() != 0) ? sbq.pop_front() : mk(1'bx, 4'bx, 32'bx, 32'bx);
        chk($sformatf("%s_exc", name), 32'(me_exc), 32'(ev.exc));
        if (ev.exc) begin
            chk($sformatf("%s_cause", name), 32'(me_exc_cause), 32'(ev.cause));
            chk($sformatf("%s_tval", name), me_exc_tval, ev.tval);
        end
        chk($sformatf("%s_wb_data", name), me_wb_data, ev.wb);
        chk($sformatf("%s_stall_in_done", name), 32'(me_stall), 32'd0);
        chk($sformatf("%s_req_in_done", name), 32'(bus.dbus_req), 32'd0);
        chk($sformatf("%s_stall_cycles", name), 32'(stall_cnt), 32'(exp_stall));
        chk($sformatf("%s_req_cycles", name), 32'(busy), 32'(exp_req));
        me_valid = 1'b0; me_mem_read = 1'b0; me_mem_write = 1'b0;
        tick();
        chk($sformatf("%s_done_pulse", name), 32'(me_done), 32'd0);
    endtask

    logic [31:0] a, w;
    logic [3:0]  b;
    logic        we;

    initial begin
        rstn = 1'b0;
        me_valid = 1'b0; me_mem_read = 1'b0; me_mem_write = 1'b0;
        me_func3_code = 3'd0; me_alu_o = 32'h55; me_regs_data2 = '0;
        bus.dbus_ack = 1'b0; bus.dbus_err = 1'b0; bus.dbus_rdata = '0;
        tick();
        tick();
        chk("rst_req",   32'(bus.dbus_req), 32'd0);
        chk("rst_we",    32'(bus.dbus_we), 32'd0);
        chk("rst_addr",  bus.dbus_addr, 32'd0);
        chk("rst_wdata", bus.dbus_wdata, 32'd0);
        chk("rst_be",    32'(bus.dbus_be), 32'd0);
        chk("rst_done",  32'(me_done), 32'd0);
        chk("rst_exc",   32'(me_exc), 32'd0);
        chk("rst_cause", 32'(me_exc_cause), 32'd0);
        chk("rst_tval",  me_exc_tval, 32'd0);
        chk("rst_stall", 32'(me_stall), 32'd0);
        chk("rst_wb",    me_wb_data, 32'h55);
        rstn = 1'b1;
        tick();

        // LB at 0x1003, ack in the second BUSY cycle
        access("lb", 1'b1, 1'b0, 3'd0, 32'h1003, 32'h0, 2, 1'b0, 32'h80AABBCC,
               mk(1'b0, 4'd0, 32'h0, 32'hFFFFFF80), 3, 2, a, w, b, we);
        chk("lb_addr", a, 32'h1000);
        chk("lb_we", 32'(we), 32'd0);

        // SH at 0x2002, upper half lanes
        access("sh", 1'b0, 1'b1, 3'd1, 32'h2002, 32'h1234ABCD, 1, 1'b0, 32'h0,
               mk(1'b0, 4'd0, 32'h0, 32'h2002), 2, 1, a, w, b, we);
        chk("sh_we", 32'(we), 32'd1);
        chk("sh_be", 32'(b), 32'hC);
        chk("sh_wdata", w, 32'hABCDABCD);
        chk("sh_addr", a, 32'h2000);

        // Misaligned LW: no bus activity
        access("lw_mis", 1'b1, 1'b0, 3'd2, 32'h3001, 32'h0, 1, 1'b0, 32'h0,
               mk(1'b1, 4'd4, 32'h3001, 32'h3001), 1, 0, a, w, b, we);

        // SW never acknowledged: timeout access fault
        access("sw_to", 1'b0, 1'b1, 3'd2, 32'h4000, 32'hDEADBEEF, 0, 1'b0, 32'h0,
               mk(1'b1, 4'd7, 32'h4000, 32'h4000), TIMEOUT + 1, TIMEOUT, a, w, b, we);
        chk("sw_to_wdata", w, 32'hDEADBEEF);
        chk("sw_to_be", 32'(b), 32'hF);

        // LHU with err and ack together: err wins
        access("lhu_err", 1'b1, 1'b0, 3'd5, 32'h5002, 32'h0, 1, 1'b1, 32'h12345678,
               mk(1'b1, 4'd5, 32'h5002, 32'h5002), 2, 1, a, w, b, we);

        // Zero/sign extension and word load
        access("lbu", 1'b1, 1'b0, 3'd4, 32'h6001, 32'h0, 1, 1'b0, 32'h0000F500,
               mk(1'b0, 4'd0, 32'h0, 32'h000000F5), 2, 1, a, w, b, we);
        access("lh", 1'b1, 1'b0, 3'd1, 32'h7002, 32'h0, 1, 1'b0, 32'h80010000,
               mk(1'b0, 4'd0, 32'h0, 32'hFFFF8001), 2, 1, a, w, b, we);
        access("lw", 1'b1, 1'b0, 3'd2, 32'h7004, 32'h0, 3, 1'b0, 32'hCAFEF00D,
               mk(1'b0, 4'd0, 32'h0, 32'hCAFEF00D), 4, 3, a, w, b, we);
        chk("lw_addr", a, 32'h7004);

        // SB at byte 1
        access("sb", 1'b0, 1'b1, 3'd0, 32'h8001, 32'h000000AB, 1, 1'b0, 32'h0,
               mk(1'b0, 4'd0, 32'h0, 32'h8001), 2, 1, a, w, b, we);
        chk("sb_be", 32'(b), 32'h2);
        chk("sb_wdata", w, 32'hABABABAB);

        // Illegal widths are access faults
        access("ld_ill", 1'b1, 1'b0, 3'd3, 32'h9000, 32'h0, 1, 1'b0, 32'h0,
               mk(1'b1, 4'd5, 32'h9000, 32'h9000), 1, 0, a, w, b, we);
        access("st_ill", 1'b0, 1'b1, 3'd3, 32'h9004, 32'h0, 1, 1'b0, 32'h0,
               mk(1'b1, 4'd7, 32'h9004, 32'h9004), 1, 0, a, w, b, we);

        // Read and write both set is a store
        access("rdwr", 1'b1, 1'b1, 3'd2, 32'hA000, 32'h11223344, 1, 1'b0, 32'h0,
               mk(1'b0, 4'd0, 32'h0, 32'hA000), 2, 1, a, w, b, we);
        chk("rdwr_we", 32'(we), 32'd1);
        chk("rdwr_wdata", w, 32'h11223344);

        // Non-memory pass-through
        me_valid = 1'b1; me_alu_o = 32'h1234;
        #1;
        chk("alu_stall", 32'(me_stall), 32'd0);
        chk("alu_wb", me_wb_data, 32'h1234);
        tick();
        chk("alu_no_done", 32'(me_done), 32'd0);
        chk("alu_no_req", 32'(bus.dbus_req), 32'd0);
        me_valid = 1'b0;

        // Reset in the middle of a transfer; late ack ignored
        me_valid = 1'b1; me_mem_read = 1'b1; me_func3_code = 3'd2; me_alu_o = 32'hB000;
        tick();
        chk("rst_mid_req_busy", 32'(bus.dbus_req), 32'd1);
        chk("rst_mid_stall_busy", 32'(me_stall), 32'd1);
        rstn = 1'b0; me_valid = 1'b0; me_mem_read = 1'b0;
        tick();
        chk("rst_mid_req", 32'(bus.dbus_req), 32'd0);
        chk("rst_mid_stall", 32'(me_stall), 32'd0);
        rstn = 1'b1; bus.dbus_ack = 1'b1; bus.dbus_rdata = 32'hFFFFFFFF;
        tick();
        chk("late_ack_no_done", 32'(me_done), 32'd0);
        bus.dbus_ack = 1'b0;
        me_valid = 1'b1; me_alu_o = 32'h77;
        #1;
        chk("add_stall", 32'(me_stall), 32'd0);
        chk("add_wb", me_wb_data, 32'h77);
        tick();
        chk("add_no_done", 32'(me_done), 32'd0);
        me_valid = 1'b0;

        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
